// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, field widths and fetch state encoding
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int ADDR_W   = 8;
  localparam int OPCODE_W = 4;
  localparam int REG_W    = 4;
  localparam int IMM_W    = 8;

  localparam logic [OPCODE_W-1:0] OP_AND   = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_LD    = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DECODE = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// rtl/fetch_pc_counter.sv - program counter with increment and load; load wins if both asserted
module fetch_pc_counter
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;

  // Natural 8-bit overflow gives the FF -> 00 wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_VAL;
    end else if (load) begin
      r_pc <= load_val;
    end else if (inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: IDLE -> REQ -> DECODE loop, stops in HALTED
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]   RESET_PC    = 8'h00,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                stall,
  input  logic                jump,
  input  logic [ADDR_W-1:0]   jump_target,
  output logic                instr_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rd,
  output logic [IMM_W-1:0]    imm,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [INSTR_W-1:0] r_ir;
  logic               w_pc_inc;
  logic               w_pc_load;
  logic               w_ir_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IR only captures in REQ, so acks arriving in any other state are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir <= '0;
    end else if (w_ir_load) begin
      r_ir <= mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    w_ir_load   = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_ir_load   = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = DECODE;
        end
      end
      DECODE: begin
        instr_valid = 1'b1;
        // Halt takes priority over a simultaneous jump.
        if (!stall) begin
          if (opcode == HALT_OPCODE) begin
            w_state_nxt = HALTED;
          end else begin
            w_pc_load   = jump;
            w_state_nxt = REQ;
          end
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  fetch_pc_counter #(
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_pc_inc),
    .load     (w_pc_load),
    .load_val (jump_target),
    .pc       (pc)
  );

  assign mem_addr = pc;
  assign opcode   = r_ir[15:12];
  assign rd       = r_ir[11:8];
  assign imm      = r_ir[7:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - transaction-level randomized bench for instr_fetch
module tb_instr_fetch;

  localparam logic [7:0] RST_PC  = 8'h00;
  localparam logic [3:0] HALT_OP = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        jump;
  logic [7:0]  jump_target;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [7:0]  imm;
  logic [7:0]  pc;
  logic        halted;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC    (RST_PC),
    .HALT_OPCODE (HALT_OP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .jump        (jump),
    .jump_target (jump_target),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .imm         (imm),
    .pc          (pc),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic noise();
    jump        = 1'($urandom);
    jump_target = 8'($urandom);
    mem_rdata   = 16'($urandom);
  endtask

  // One complete instruction: wait states, ack, stalled decode, then the exit decision.
  task automatic fetch(input int delay, input logic [15:0] data, input int nstall,
                       input logic do_jump, input logic [7:0] tgt);
    for (int i = 0; i < delay; i++) begin
      check("req_hold", 32'(mem_req), 1);
      check("addr_hold", 32'(mem_addr), 32'(exp_pc));
      check("no_early_valid", 32'(instr_valid), 0);
      noise();
      stall   = 1'($urandom);
      mem_ack = 1'b0;
      tick();
    end
    check("req", 32'(mem_req), 1);
    check("addr", 32'(mem_addr), 32'(exp_pc));
    check("pc_in_req", 32'(pc), 32'(exp_pc));
    check("no_valid_in_req", 32'(instr_valid), 0);
    noise();
    stall     = 1'($urandom);
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    exp_pc = exp_pc + 8'd1;
    for (int i = 0; i <= nstall; i++) begin
      check("valid", 32'(instr_valid), 1);
      check("req_low_decode", 32'(mem_req), 0);
      check("opcode", 32'(opcode), 32'(data[15:12]));
      check("rd", 32'(rd), 32'(data[11:8]));
      check("imm", 32'(imm), 32'(data[7:0]));
      check("pc_decode", 32'(pc), 32'(exp_pc));
      check("halted_decode", 32'(halted), 0);
      if (i < nstall) begin
        noise();
        stall   = 1'b1;
        mem_ack = 1'($urandom);
        tick();
      end
    end
    stall       = 1'b0;
    jump        = do_jump;
    jump_target = tgt;
    mem_ack     = 1'($urandom);
    mem_rdata   = 16'($urandom);
    tick();
    mem_ack = 1'b0;
    jump    = 1'b0;
    if (data[15:12] == HALT_OP) begin
      for (int i = 0; i < 20; i++) begin
        check("halted", 32'(halted), 1);
        check("req_low_halted", 32'(mem_req), 0);
        check("valid_low_halted", 32'(instr_valid), 0);
        check("pc_halted", 32'(pc), 32'(exp_pc));
        noise();
        stall   = 1'($urandom);
        mem_ack = 1'($urandom);
        tick();
      end
    end else if (do_jump) begin
      exp_pc = tgt;
    end
  endtask

  initial begin
    logic [15:0] d;
    reset       = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    stall       = 1'b0;
    jump        = 1'b0;
    jump_target = '0;
    tick();
    tick();
    check("rst_req", 32'(mem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_pc", 32'(pc), 32'(RST_PC));
    check("rst_addr", 32'(mem_addr), 32'(RST_PC));
    check("rst_ir", 32'({opcode, rd, imm}), 0);
    reset = 1'b0;
    check("idle_no_req", 32'(mem_req), 0);
    tick();
    exp_pc = RST_PC;

    fetch(0, 16'h2A05, 0, 1'b0, 8'h00);
    fetch(1, 16'h1111, 0, 1'b1, 8'h10);
    fetch(3, 16'h3C7E, 5, 1'b0, 8'h00);
    fetch(0, 16'h4455, 0, 1'b1, 8'h40);
    fetch(2, 16'h0123, 1, 1'b1, 8'hFF);
    fetch(0, 16'h6789, 0, 1'b0, 8'h00);

    for (int n = 0; n < 40; n++) begin
      d = 16'($urandom);
      if (d[15:12] == HALT_OP) d[15:12] = 4'h2;
      fetch(int'($urandom_range(0, 3)), d, int'($urandom_range(0, 3)),
            1'($urandom), 8'($urandom));
    end

    fetch(0, 16'h1234, 0, 1'b1, 8'h20);
    mem_ack = 1'b0;
    reset   = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req), 0);
    check("mid_rst_pc", 32'(pc), 32'(RST_PC));
    check("mid_rst_ir", 32'({opcode, rd, imm}), 0);
    #1;
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("late_ack_ir", 32'({opcode, rd, imm}), 0);
    check("post_rst_req", 32'(mem_req), 1);
    check("post_rst_addr", 32'(mem_addr), 32'(RST_PC));
    exp_pc = RST_PC;
    fetch(1, 16'h5A5A, 0, 1'b0, 8'h00);

    fetch(1, 16'hF000, 2, 1'b1, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 4'hF, meaning the opcode that stops fetching.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port mem_req, output, 1, instruction-memory read request.
REQ-006 The block SHALL have port mem_addr, output, 8, instruction-memory read address.
REQ-007 The block SHALL have port mem_ack, input, 1, read data valid for the current request.
REQ-008 The block SHALL have port mem_rdata, input, 16, instruction word; it is sampled only when mem_ack=1.
REQ-009 The block SHALL have port stall, input, 1, a downstream hold request.
REQ-010 The block SHALL have port jump, input, 1, the control-unit Jump output.
REQ-011 The block SHALL have port jump_target, input, 8, the control-unit address output.
REQ-012 The block SHALL have port instr_valid, output, 1, meaning opcode/rd/imm are valid.
REQ-013 The block SHALL have port opcode, output, 4, IR[15:12], which feeds the control unit.
REQ-014 The block SHALL have port rd, output, 4, IR[11:8].
REQ-015 The block SHALL have port imm, output, 8, IR[7:0].
REQ-016 The block SHALL have port pc, output, 8, the current program counter.
REQ-017 The block SHALL have port halted, output, 1, which is high in the HALTED state.

Function
REQ-018 The block SHALL use four states: IDLE, REQ, DECODE, HALTED.
REQ-019 IDLE SHALL last exactly one cycle, then go to REQ.
REQ-020 In REQ, the block SHALL drive mem_req=1 and mem_addr=pc, both held stable until mem_ack.
REQ-021 REQ with mem_ack=1 SHALL:
- latch mem_rdata into the IR;
- set pc<=pc+1 (8'hFF wraps to 8'h00);
- go to DECODE.
REQ-022 A mem_ack that arrives while the block is not in REQ SHALL be ignored.
REQ-023 In DECODE, the block SHALL drive instr_valid=1 and mem_req=0.
REQ-024 In DECODE with stall=1, the block SHALL remain in DECODE with the IR, pc and outputs unchanged.
REQ-025 In DECODE with stall=0 and opcode==HALT_OPCODE, the block SHALL go to HALTED; jump is ignored.
REQ-026 In DECODE with stall=0 and jump=1, the block SHALL set pc<=jump_target and go to REQ.
REQ-027 In DECODE otherwise, the block SHALL go to REQ.
REQ-028 jump SHALL be sampled only in DECODE with stall=0, and ignored in every other state.
REQ-029 HALTED SHALL be left only by reset; in it, mem_req=0, instr_valid=0 and halted=1.
REQ-030 Latency: mem_ack in cycle N SHALL give instr_valid=1 in cycle N+1.
REQ-031 Minimum issue interval SHALL be 2 cycles per instruction.
REQ-032 opcode, rd and imm SHALL always reflect the IR, and SHALL be qualified by instr_valid.

Reset
REQ-033 Asserting reset SHALL immediately force:
- state=IDLE;
- pc=RESET_PC;
- IR=16'h0000;
- mem_req=0, instr_valid=0, halted=0;
- mem_addr=RESET_PC.
REQ-034 Reset asserted in mid-request SHALL abandon the request; a later mem_ack SHALL NOT update the IR.
REQ-035 After reset deasserts, the first mem_req SHALL occur on the second rising clk edge.

Structure
REQ-036 Package cpu_pkg SHALL hold:
- the opcode constants (AND 4'h0, OR 4'h1, ADD 4'h2, SUB 4'h3, LD 4'h4, STORE 4'h5, JMP 4'h6, HALT 4'hF);
- the fetch state enum;
- the field widths (instruction 16, address 8).
REQ-037 The PC increment/load logic SHALL be a sub-module fetch_pc_counter (inputs: inc, load, load_val).

Verification
REQ-038 Verification SHALL cover these directed scenarios:
- Reset, then memory returns 16'h2A05 with ack on the first REQ cycle -> instr_valid next cycle; opcode=2, rd=A, imm=05, pc=01.
- mem_ack delayed 3 cycles at pc=8'h10 -> mem_req and mem_addr=8'h10 held for 4 cycles; no instr_valid before ack.
- Stall held 5 cycles in DECODE -> instr_valid and outputs stable; no mem_req; pc unchanged.
- DECODE with jump=1, jump_target=8'h40 -> next mem_addr=8'h40.
- pc=8'hFF fetch -> pc wraps to 8'h00.
- HALT opcode 16'hF000 with jump=1 -> halted=1 and no further mem_req for 20 cycles.
- Reset pulsed in REQ then a late ack -> IR stays 0; next mem_addr=RESET_PC.
